// File: rtl/ws2812b_frame_scheduler_if.sv
// Host-side bundle for the WS2812B frame scheduler: buffer write port, frame
// start request, frame status, the serial data line and the FSM state for debug.
interface ws2812b_frame_scheduler_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic       dout;
  logic [1:0] state;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, dout, state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, dout, state
  );
endinterface

// File: rtl/ws2812b_frame_scheduler.sv
// WS2812B transmit scheduler: GRB pixel buffer serialised MSB-first with a latch gap.
// Optional WS2812B_SCHED_AUTO_REFRESH_EN adds auto_refresh for back-to-back frames.
module ws2812b_frame_scheduler #(
  parameter int NUM_PIXELS   = 4,
  parameter int T0H_CYCLES   = 26,
  parameter int T1H_CYCLES   = 51,
  parameter int BIT_CYCLES   = 80,
  parameter int RESET_CYCLES = 3840
) (
  input  logic clk,
  input  logic reset,
`ifdef WS2812B_SCHED_AUTO_REFRESH_EN
  input  logic auto_refresh,
`endif
  ws2812b_frame_scheduler_if.slave bus
);

  // Handshake: start is a one-cycle request honoured only while busy=0; busy
  // stays high from the first dout rise until the cycle done pulses.
  localparam int NB = 3 * NUM_PIXELS;
  localparam int CW = $clog2(RESET_CYCLES + 1);

  localparam logic [CW-1:0] T0H_M1   = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1H_M1   = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] T0L_M1   = CW'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1L_M1   = CW'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_M1 = CW'(RESET_CYCLES - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    byte_idx, byte_next;
  logic [2:0]    bit_idx, bit_next;
  logic          done_q, done_next;
  logic          dout_q;
  logic          refresh;
  logic          cur_bit;
  logic          last_bit;
  logic          wr_ok;
  logic [7:0]    pix_buf [NB];

`ifdef WS2812B_SCHED_AUTO_REFRESH_EN
  assign refresh = auto_refresh;
`else
  assign refresh = 1'b0;
`endif

  assign cur_bit  = pix_buf[byte_idx][bit_idx];
  assign last_bit = (byte_idx == LAST_BYTE) && (bit_idx == 3'd0);
  // Writes land only while idle so a frame in flight never tears.
  assign wr_ok    = bus.wr_en && (state == IDLE) && (bus.wr_addr < 4'(NB));

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    byte_next  = byte_idx;
    bit_next   = bit_idx;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (bus.start) begin
          state_next = HIGH;
          byte_next  = 4'd0;
          bit_next   = 3'd7;
        end
      end
      HIGH: begin
        if (cnt == (cur_bit ? T1H_M1 : T0H_M1)) begin
          state_next = LOW;
          cnt_next   = '0;
        end
      end
      LOW: begin
        if (cnt == (cur_bit ? T1L_M1 : T0L_M1)) begin
          cnt_next = '0;
          if (last_bit) begin
            state_next = LATCH;
          end else begin
            state_next = HIGH;
            bit_next   = bit_idx - 3'd1;
            if (bit_idx == 3'd0) byte_next = byte_idx + 4'd1;
          end
        end
      end
      LATCH: begin
        if (cnt == LATCH_M1) begin
          cnt_next  = '0;
          done_next = 1'b1;
          if (refresh) begin
            state_next = HIGH;
            byte_next  = 4'd0;
            bit_next   = 3'd7;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      dout_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NB; i++) pix_buf[i] <= 8'h00;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      byte_idx <= byte_next;
      bit_idx  <= bit_next;
      dout_q   <= (state_next == HIGH);
      done_q   <= done_next;
      if (wr_ok) pix_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state != IDLE);
  assign bus.state = state;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Bench for ws2812b_frame_scheduler: directed frames, a bit/frame scoreboard and
// a monitor that decodes dout pulse widths and frame lengths.
module tb_ws2812b_frame_scheduler;
  localparam int NB    = 12;
  localparam int BIT   = 80;
  localparam int T0H   = 26;
  localparam int T1H   = 51;
  localparam int FRAME = 11520;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812b_frame_scheduler_if bus();
`ifdef WS2812B_SCHED_AUTO_REFRESH_EN
  logic auto_refresh;
`endif

  ws2812b_frame_scheduler dut (
    .clk          (clk),
    .reset        (reset),
`ifdef WS2812B_SCHED_AUTO_REFRESH_EN
    .auto_refresh (auto_refresh),
`endif
    .bus          (bus)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int         frame_q[$];
  logic [7:0] model_buf [NB];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // monitor
  int   bits_seen  = 0;
  int   done_count = 0;
  int   rise_t     = 0;
  int   frame_t0   = 0;
  bit   in_frame   = 1'b0;
  logic dout_prev  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame  = 1'b0;
        dout_prev = 1'b0;
      end else begin
        if (bus.done) begin
          done_count++;
          if (frame_q.size() == 0) report_fail("unexpected_done");
          else check("frame_len", cyc - frame_t0, frame_q.pop_front());
          in_frame = 1'b0;
        end
        if (bus.dout && !dout_prev) begin
          if (in_frame) check("bit_period", cyc - rise_t, BIT);
          else begin
            in_frame = 1'b1;
            frame_t0 = cyc;
          end
          rise_t = cyc;
        end
        if (!bus.dout && dout_prev) begin
          bits_seen++;
          if (exp_q.size() == 0) report_fail("unexpected_bit");
          else check("high_width", cyc - rise_t, exp_q.pop_front());
        end
        dout_prev = bus.dout;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int b = 0; b < NB; b++)
      for (int i = 7; i >= 0; i--)
        exp_q.push_back(model_buf[b][i] ? 8'(T1H) : 8'(T0H));
    frame_q.push_back(FRAME);
  endtask

  task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    if (int'(a) < NB) model_buf[a] = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic start_frame();
    push_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input logic exp_busy);
    bit seen = 1'b0;
    for (int i = 0; i < FRAME + 500 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        check("busy_at_done", int'(bus.busy), int'(exp_busy));
      end
    end
    if (!seen) report_fail("done_timeout");
    tick();
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 10000 && bits_seen < n; i++) @(negedge clk);
    check("bits_reached", int'(bits_seen >= n), 1);
    tick();
  endtask

  initial begin
    int base;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = 8'h00;
    bus.start   = 1'b0;
`ifdef WS2812B_SCHED_AUTO_REFRESH_EN
    auto_refresh = 1'b0;
`endif
    for (int i = 0; i < NB; i++) model_buf[i] = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_dout", int'(bus.dout), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_state", int'(bus.state), 0);
    tick();

    // single '1' bit then 95 zeros
    write_byte(4'd0, 8'h80);
    start_frame();
    check("busy_after_start", int'(bus.busy), 1);
    wait_done(1'b0);

    // colour pattern; byte 2 written in the same cycle as start
    write_byte(4'd0, 8'hA5);
    write_byte(4'd1, 8'h3C);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 8'hFF;
    model_buf[2] = 8'hFF;
    push_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    wait_done(1'b0);

    // start and write mid-frame are both ignored
    base = bits_seen;
    start_frame();
    wait_bits(base + 48);
    bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h11;
    tick();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    wait_done(1'b0);
    repeat (200) tick();
    check("done_count_mid", done_count, 3);

    // reset at bit 40; first 24 bits also prove buffer[0] kept 0xA5
    base = bits_seen;
    start_frame();
    wait_bits(base + 40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    frame_q.delete();
    for (int i = 0; i < NB; i++) model_buf[i] = 8'h00;
    @(negedge clk);
    check("abort_dout", int'(bus.dout), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_state", int'(bus.state), 0);
    tick();
    repeat (100) tick();
    check("done_count_abort", done_count, 3);

    // out-of-range write, then an all-zero frame from the cleared buffer
    write_byte(4'd12, 8'hFF);
    start_frame();
    wait_done(1'b0);
    check("done_count_clear", done_count, 4);

`ifdef WS2812B_SCHED_AUTO_REFRESH_EN
    write_byte(4'd5, 8'hC3);
    auto_refresh = 1'b1;
    push_frame();
    start_frame();
    wait_done(1'b1);
    auto_refresh = 1'b0;
    wait_done(1'b0);
    repeat (50) tick();
    check("refresh_state", int'(bus.state), 0);
    check("done_count_refresh", done_count, 6);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    check("frame_q_empty", frame_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
